// File: rtl/rx_channel.sv
// rx_channel: DUART channel receive front end.
// 16x oversampled async deserialiser feeding a 3-deep character FIFO.
module rx_channel #(
  parameter int FIFO_DEPTH = 3,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  input  logic       i_baud16_en,
  input  logic       i_rx_enable,
  input  logic [1:0] i_bits,
  input  logic       i_par_en,
  input  logic       i_par_odd,
  input  logic       i_rd_strobe,
  input  logic       i_err_clr,
  output logic [7:0] o_rx_data,
  output logic       o_par_err,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_rxrdy,
  output logic       o_ffull
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CMAX = CW'(OVERSAMPLE - 1);
  localparam logic [1:0] DMAX = 2'(FIFO_DEPTH - 1);
  localparam logic [1:0] DFULL = 2'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HI
  } state_t;

  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    r_bidx;
  logic [2:0]    w_bidx_nx;
  logic [7:0]    r_data;
  logic [7:0]    w_data_nx;
  logic          r_par_bit;
  logic          w_par_bit_nx;
  logic          w_mid;
  logic          w_last_bit;
  logic          w_push_req;
  logic [9:0]    w_char;

  assign w_mid      = i_baud16_en && (r_cnt == MID);
  assign w_last_bit = (r_bidx == (3'd4 + {1'b0, i_bits}));
  // Character record is {data, parity error, framing error}
  assign w_char = {r_data,
                   i_par_en & (^r_data ^ r_par_bit ^ i_par_odd),
                   ~r_rx_s};

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_bidx_nx    = r_bidx;
    w_data_nx    = r_data;
    w_par_bit_nx = r_par_bit;
    w_push_req   = 1'b0;
    if (i_baud16_en)
      w_cnt_nx = (r_cnt == CMAX) ? '0 : r_cnt + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!r_rx_s)
          w_state_nx = S_START;
      end
      S_START: begin
        if (w_mid) begin
          if (r_rx_s) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_DATA;
            w_bidx_nx  = '0;
            w_data_nx  = '0;
          end
        end
      end
      S_DATA: begin
        if (w_mid) begin
          w_data_nx[r_bidx] = r_rx_s;
          w_bidx_nx = r_bidx + 1'b1;
          if (w_last_bit)
            w_state_nx = i_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_mid) begin
          w_par_bit_nx = r_rx_s;
          w_state_nx   = S_STOP;
        end
      end
      S_STOP: begin
        if (w_mid) begin
          w_push_req = 1'b1;
          w_state_nx = r_rx_s ? S_IDLE : S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (r_rx_s)
          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    // Disable aborts any partial character without touching the FIFO
    if (!i_rx_enable) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_push_req = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bidx    <= '0;
      r_data    <= '0;
      r_par_bit <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bidx    <= w_bidx_nx;
      r_data    <= w_data_nx;
      r_par_bit <= w_par_bit_nx;
    end
  end

  logic [9:0] r_mem [FIFO_DEPTH];
  logic [1:0] r_wr;
  logic [1:0] r_rd;
  logic [1:0] r_count;
  logic [9:0] r_head;
  logic       r_ovr;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_rd_nx;
  logic [1:0] w_count_nx;
  logic [9:0] w_head_nx;

  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == DMAX) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pop      = i_rd_strobe && (r_count != 2'd0);
  assign w_push     = w_push_req && ((r_count != DFULL) || w_pop);
  assign w_rd_nx    = w_pop ? f_inc(r_rd) : r_rd;
  assign w_count_nx = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // Head is re-registered; an emptied FIFO keeps showing the last character
  always_comb begin
    w_head_nx = r_head;
    if (w_count_nx != 2'd0)
      w_head_nx = (w_push && (r_wr == w_rd_nx)) ? w_char : r_mem[w_rd_nx];
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr] <= w_char;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_push)
        r_wr <= f_inc(r_wr);
      r_rd    <= w_rd_nx;
      r_count <= w_count_nx;
      r_head  <= w_head_nx;
      r_ovr   <= (r_ovr && !i_err_clr) || (w_push_req && !w_push);
    end
  end

  assign o_rx_data   = r_head[9:2];
  assign o_par_err   = r_head[1];
  assign o_frame_err = r_head[0];
  assign o_overrun   = r_ovr;
  assign o_rxrdy     = (r_count != 2'd0);
  assign o_ffull     = (r_count == DFULL);

endmodule

// File: tb/tb_rx_channel.sv
// tb_rx_channel: vector table, corner sequences and a
// randomized run against a queue-based FIFO/UART model.
`timescale 1ns/1ps
module tb_rx_channel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       baud;
  logic       en;
  logic [1:0] bits;
  logic       par_en;
  logic       par_odd;
  logic       rd;
  logic       eclr;
  logic [7:0] data;
  logic       pe;
  logic       fe;
  logic       ovr;
  logic       rdy;
  logic       full;
  logic [1:0] bc = 2'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) bc <= bc + 2'd1;
  assign baud = (bc == 2'd3);

  rx_channel dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_rx        (rx),
    .i_baud16_en (baud),
    .i_rx_enable (en),
    .i_bits      (bits),
    .i_par_en    (par_en),
    .i_par_odd   (par_odd),
    .i_rd_strobe (rd),
    .i_err_clr   (eclr),
    .o_rx_data   (data),
    .o_par_err   (pe),
    .o_frame_err (fe),
    .o_overrun   (ovr),
    .o_rxrdy     (rdy),
    .o_ffull     (full)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One bit time is 16 baud ticks of 4 clocks each
  task automatic tbit(input logic v);
    rx = v;
    repeat (64) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int n,
                      input logic pen, input logic pb,
                      input logic stop);
    tbit(1'b0);
    for (int i = 0; i < n; i++) tbit(d[i]);
    if (pen) tbit(pb);
    tbit(stop);
    tbit(1'b1);
  endtask

  task automatic pop();
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic clr();
    eclr = 1'b1;
    @(posedge clk);
    #1;
    eclr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    rd = 1'b0;
    eclr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference model: character queue plus sticky overrun
  logic [9:0] q[$];
  logic       movr;
  logic [9:0] m_last;

  function automatic logic [9:0] m_char(input logic [7:0] d, input int n,
                                        input logic pen, input logic odd,
                                        input logic pb, input logic stop);
    logic [7:0] v;
    int ones;
    v = d & 8'((1 << n) - 1);
    ones = $countones(v) + int'(pb);
    return {v, pen && ((ones % 2 == 1) != odd), !stop};
  endfunction

  task automatic m_push(input logic [9:0] c);
    if (q.size() < 3) q.push_back(c);
    else movr = 1'b1;
    if (q.size() > 0) m_last = q[0];
  endtask

  task automatic m_pop();
    if (q.size() > 0) void'(q.pop_front());
    if (q.size() > 0) m_last = q[0];
  endtask

  task automatic m_check(input string t);
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : m_last;
    chk({t, "_rdy"}, rdy, q.size() > 0);
    chk({t, "_full"}, full, q.size() == 3);
    chk({t, "_ovr"}, ovr, movr);
    chk({t, "_data"}, data, h[9:2]);
    chk({t, "_pe"}, pe, h[1]);
    chk({t, "_fe"}, fe, h[0]);
  endtask

  typedef struct {
    logic [7:0] d;
    int         n;
    logic       pen;
    logic       odd;
    logic       pb;
    logic       stop;
    logic [7:0] xd;
    logic       xpe;
    logic       xfe;
  } vec_t;

  vec_t tbl[10];
  int   tk;
  int   n;
  int   nr;
  int   ones;
  logic [7:0] d;
  logic pb;
  logic stop;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h03, 8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[4] = '{8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
    tbl[6] = '{8'hC3, 7, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0};
    tbl[7] = '{8'h2A, 6, 1'b1, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
    tbl[8] = '{8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    tbl[9] = '{8'h8B, 7, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b1};

    en = 1'b1;
    bits = 2'd3;
    par_en = 1'b0;
    par_odd = 1'b0;
    do_reset();
    chk("reset_data", data, 8'h00);
    chk("reset_pe", pe, 1'b0);
    chk("reset_fe", fe, 1'b0);
    chk("reset_ovr", ovr, 1'b0);
    chk("reset_rdy", rdy, 1'b0);
    chk("reset_full", full, 1'b0);

    for (int i = 0; i < 10; i++) begin
      bits = 2'(tbl[i].n - 5);
      par_en = tbl[i].pen;
      par_odd = tbl[i].odd;
      send(tbl[i].d, tbl[i].n, tbl[i].pen, tbl[i].pb, tbl[i].stop);
      chk($sformatf("tbl%0d_rdy", i), rdy, 1'b1);
      chk($sformatf("tbl%0d_data", i), data, tbl[i].xd);
      chk($sformatf("tbl%0d_pe", i), pe, tbl[i].xpe);
      chk($sformatf("tbl%0d_fe", i), fe, tbl[i].xfe);
      pop();
      chk($sformatf("tbl%0d_rdy_rd", i), rdy, 1'b0);
      chk($sformatf("tbl%0d_hold", i), data, tbl[i].xd);
    end

    bits = 2'd3;
    par_en = 1'b0;
    send(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send(8'h22, 8, 1'b0, 1'b0, 1'b1);
    send(8'h33, 8, 1'b0, 1'b0, 1'b1);
    chk("ovr_full", full, 1'b1);
    chk("ovr_head", data, 8'h11);
    chk("ovr_pre", ovr, 1'b0);
    send(8'h44, 8, 1'b0, 1'b0, 1'b1);
    chk("ovr_set", ovr, 1'b1);
    chk("ovr_full2", full, 1'b1);
    pop();
    chk("ovr_rd1", data, 8'h22);
    pop();
    chk("ovr_rd2", data, 8'h33);
    pop();
    chk("ovr_rd3_rdy", rdy, 1'b0);
    chk("ovr_rd3_data", data, 8'h33);
    pop();
    chk("empty_pop_data", data, 8'h33);
    chk("empty_pop_rdy", rdy, 1'b0);
    chk("ovr_sticky", ovr, 1'b1);
    clr();
    chk("ovr_clr", ovr, 1'b0);

    send(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send(8'h22, 8, 1'b0, 1'b0, 1'b1);
    send(8'h33, 8, 1'b0, 1'b0, 1'b1);
    fork
      send(8'h44, 8, 1'b0, 1'b0, 1'b1);
      begin
        tk = 0;
        repeat (3) @(posedge clk);
        #1;
        while (tk < 152) begin
          if (baud) begin
            tk++;
            if (tk == 152) rd = 1'b1;
          end
          @(posedge clk);
          #1;
        end
        rd = 1'b0;
      end
    join
    chk("pp_ovr", ovr, 1'b0);
    chk("pp_full", full, 1'b1);
    chk("pp_rd1", data, 8'h22);
    pop();
    chk("pp_rd2", data, 8'h33);
    pop();
    chk("pp_rd3", data, 8'h44);
    pop();
    chk("pp_empty", rdy, 1'b0);

    for (int i = 0; i < 12; i++) tbit(1'b0);
    tbit(1'b1);
    tbit(1'b1);
    chk("brk_rdy", rdy, 1'b1);
    chk("brk_full", full, 1'b0);
    chk("brk_data", data, 8'h00);
    chk("brk_fe", fe, 1'b1);
    chk("brk_pe", pe, 1'b0);
    pop();
    chk("brk_one", rdy, 1'b0);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    chk("brk_next_data", data, 8'h3C);
    chk("brk_next_fe", fe, 1'b0);
    pop();

    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    chk("glitch_rdy", rdy, 1'b0);

    tbit(1'b0);
    tbit(1'b1);
    tbit(1'b0);
    en = 1'b0;
    for (int i = 0; i < 6; i++) tbit(1'b0);
    tbit(1'b1);
    en = 1'b1;
    tbit(1'b1);
    chk("dis_drop", rdy, 1'b0);
    send(8'h77, 8, 1'b0, 1'b0, 1'b1);
    chk("dis_next", data, 8'h77);

    tbit(1'b0);
    tbit(1'b1);
    tbit(1'b0);
    tbit(1'b1);
    rst_n = 1'b0;
    #2;
    chk("rstmid_data", data, 8'h00);
    chk("rstmid_rdy", rdy, 1'b0);
    chk("rstmid_fe", fe, 1'b0);
    chk("rstmid_ovr", ovr, 1'b0);
    rx = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tbit(1'b1);
    send(8'h96, 8, 1'b0, 1'b0, 1'b1);
    chk("rstmid_next", data, 8'h96);
    chk("rstmid_next_rdy", rdy, 1'b1);
    chk("rstmid_next_full", full, 1'b0);

    do_reset();
    q.delete();
    movr = 1'b0;
    m_last = '0;
    m_check("rnd_init");
    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(8, 5);
      bits = 2'(n - 5);
      par_en = 1'($urandom_range(1, 0));
      par_odd = 1'($urandom_range(1, 0));
      d = 8'($urandom);
      ones = $countones(d & 8'((1 << n) - 1));
      pb = par_odd ? (ones % 2 == 0) : (ones % 2 == 1);
      if ($urandom_range(3, 0) == 0) pb = !pb;
      stop = ($urandom_range(4, 0) != 0);
      send(d, n, par_en, pb, stop);
      m_push(m_char(d, n, par_en, par_odd, pb, stop));
      m_check("rnd_rx");
      nr = $urandom_range(2, 0);
      for (int j = 0; j < nr; j++) begin
        pop();
        m_pop();
        m_check("rnd_rd");
      end
      if ($urandom_range(5, 0) == 0) begin
        clr();
        movr = 1'b0;
        m_check("rnd_clr");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
